// File: rtl/mem_write_checker.sv
// mem_write_checker: scoreboard comparing memory-write events against a loadable expected table
module mem_write_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 100,
    parameter int ORDERED = 1,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [IW-1:0]    load_idx,
    input  logic [WIDTH-1:0] load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CW-1:0]    num_expected,
    input  logic             start,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CW-1:0]    match_cnt,
    output logic [CW-1:0]    err_cnt,
    output logic [IW-1:0]    err_idx,
    output logic [WIDTH-1:0] err_addr,
    output logic [WIDTH-1:0] err_data
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] tbl_addr_q [DEPTH], tbl_addr_d [DEPTH];
    logic [WIDTH-1:0] tbl_data_q [DEPTH], tbl_data_d [DEPTH];
    logic [DEPTH-1:0] matched_q, matched_d;
    logic [CW-1:0]    n_q, n_d, match_cnt_q, match_cnt_d, err_cnt_q, err_cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d, err_idx_q, err_idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] err_addr_q, err_addr_d, err_data_q, err_data_d;
    logic [CW-1:0]    num_clamp;
    logic             arm, ev, expire, last, any_hit, hit;
    logic [IW-1:0]    any_idx;
    assign num_clamp = (num_expected > CW'(DEPTH)) ? CW'(DEPTH) : num_expected;
    assign arm    = start && (state_q != RUN);
    assign ev     = (state_q == RUN) && memwrite;
    assign expire = (state_q == RUN) && !memwrite && (timer_q == TW'(TIMEOUT - 1));
    assign last   = ev && ((match_cnt_q + err_cnt_q + CW'(1)) == n_q);
    // Lowest unmatched entry inside the active range wins in any-order mode
    always_comb begin
        any_hit = 1'b0;
        any_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!matched_q[i] && (CW'(i) < n_q) && tbl_addr_q[i] == dataadr && tbl_data_q[i] == writedata) begin
                any_hit = 1'b1;
                any_idx = IW'(i);
            end
    end
    assign hit = (ORDERED != 0) ? (tbl_addr_q[ptr_q] == dataadr && tbl_data_q[ptr_q] == writedata) : any_hit;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tbl_addr_q  <= '{default: '0};
            tbl_data_q  <= '{default: '0};
            matched_q   <= '0;
            n_q         <= '0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
            ptr_q       <= '0;
            err_idx_q   <= '0;
            timer_q     <= '0;
            timeout_q   <= 1'b0;
            err_addr_q  <= '0;
            err_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            tbl_addr_q  <= tbl_addr_d;
            tbl_data_q  <= tbl_data_d;
            matched_q   <= matched_d;
            n_q         <= n_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ptr_q       <= ptr_d;
            err_idx_q   <= err_idx_d;
            timer_q     <= timer_d;
            timeout_q   <= timeout_d;
            err_addr_q  <= err_addr_d;
            err_data_q  <= err_data_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = arm ? ((num_clamp == '0) ? DONE : RUN) : state_q;
            RUN:        state_d = (last || expire) ? DONE : RUN;
            default:    state_d = IDLE;
        endcase
    end
    always_comb begin
        tbl_addr_d  = tbl_addr_q;
        tbl_data_d  = tbl_data_q;
        matched_d   = matched_q;
        n_d         = n_q;
        match_cnt_d = match_cnt_q;
        err_cnt_d   = err_cnt_q;
        ptr_d       = ptr_q;
        err_idx_d   = err_idx_q;
        timer_d     = timer_q;
        timeout_d   = timeout_q;
        err_addr_d  = err_addr_q;
        err_data_d  = err_data_q;
        if (load_en && state_q != RUN) begin
            tbl_addr_d[load_idx] = load_addr;
            tbl_data_d[load_idx] = load_data;
        end
        if (arm) begin
            n_d         = num_clamp;
            matched_d   = '0;
            match_cnt_d = '0;
            err_cnt_d   = '0;
            ptr_d       = '0;
            err_idx_d   = '0;
            timer_d     = '0;
            timeout_d   = 1'b0;
            err_addr_d  = '0;
            err_data_d  = '0;
        end else if (ev) begin
            timer_d = '0;
            ptr_d   = ptr_q + IW'(1);
            if (hit) begin
                match_cnt_d = match_cnt_q + CW'(1);
                if (ORDERED == 0) matched_d[any_idx] = 1'b1;
            end else begin
                err_cnt_d = err_cnt_q + CW'(1);
                if (err_cnt_q == '0) begin
                    err_idx_d  = IW'(match_cnt_q + err_cnt_q);
                    err_addr_d = dataadr;
                    err_data_d = writedata;
                end
            end
        end else if (state_q == RUN) begin
            timeout_d = expire;
            timer_d   = expire ? timer_q : timer_q + TW'(1);
        end
    end
    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        pass      = done && (err_cnt_q == '0) && !timeout_q;
        timeout   = timeout_q;
        match_cnt = match_cnt_q;
        err_cnt   = err_cnt_q;
        err_idx   = err_idx_q;
        err_addr  = err_addr_q;
        err_data  = err_data_q;
    end
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed bench driving an in-order and an any-order checker on one shared bus
module tb_mem_write_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [2:0]  load_idx = '0;
    logic [31:0] load_addr = '0, load_data = '0;
    logic [3:0]  num_expected = '0;
    logic        start = 1'b0, memwrite = 1'b0;
    logic [31:0] dataadr = '0, writedata = '0;
    logic        o_busy, o_done, o_pass, o_timeout, a_busy, a_done, a_pass, a_timeout;
    logic [3:0]  o_match, o_err, a_match, a_err;
    logic [2:0]  o_eidx, a_eidx;
    logic [31:0] o_eaddr, o_edata, a_eaddr, a_edata;
    int          pass_cnt = 0, tot_cnt = 0;
    logic [31:0] ea [5];
    logic [31:0] ed [5];

    always #5 clk = ~clk;

    mem_write_checker #(.WIDTH(32), .DEPTH(8), .TIMEOUT(16), .ORDERED(1)) u_ord (
        .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_addr(load_addr),
        .load_data(load_data), .num_expected(num_expected), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .busy(o_busy), .done(o_done), .pass(o_pass),
        .timeout(o_timeout), .match_cnt(o_match), .err_cnt(o_err), .err_idx(o_eidx),
        .err_addr(o_eaddr), .err_data(o_edata));

    mem_write_checker #(.WIDTH(32), .DEPTH(8), .TIMEOUT(16), .ORDERED(0)) u_any (
        .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_addr(load_addr),
        .load_data(load_data), .num_expected(num_expected), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .busy(a_busy), .done(a_done), .pass(a_pass),
        .timeout(a_timeout), .match_cnt(a_match), .err_cnt(a_err), .err_idx(a_eidx),
        .err_addr(a_eaddr), .err_data(a_edata));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [2:0] i, input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_idx = i; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic arm(input logic [3:0] n);
        num_expected = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        step();
        memwrite = 1'b0;
    endtask

    initial begin
        ea = '{32'h50, 32'h54, 32'h58, 32'h5c, 32'h60};
        ed = '{32'h7, 32'h7, 32'h32, 32'h17, 32'h19};
        step(2);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_pass", o_pass, 0);
        check("rst_match", o_match, 0);
        reset = 1'b0;
        step();
        for (int i = 0; i < 5; i++) load(3'(i), ea[i], ed[i]);

        // in-order, all correct, 3 idle cycles apart
        arm(5);
        check("ord_busy", o_busy, 1);
        for (int i = 0; i < 5; i++) begin
            wr(ea[i], ed[i]);
            if (i < 4) step(3);
        end
        check("ord_done", o_done, 1);
        check("ord_busy_fall", o_busy, 0);
        check("ord_pass", o_pass, 1);
        check("ord_match", o_match, 5);
        check("ord_err", o_err, 0);

        // in-order, third write corrupted
        arm(5);
        for (int i = 0; i < 5; i++) wr(ea[i], (i == 2) ? 32'h33 : ed[i]);
        check("bad_err", o_err, 1);
        check("bad_match", o_match, 4);
        check("bad_idx", o_eidx, 2);
        check("bad_addr", o_eaddr, 32'h58);
        check("bad_data", o_edata, 32'h33);
        check("bad_pass", o_pass, 0);
        check("bad_done", o_done, 1);

        // any-order, reversed
        arm(5);
        for (int i = 4; i >= 0; i--) wr(ea[i], ed[i]);
        check("rev_pass", a_pass, 1);
        check("rev_match", a_match, 5);

        // any-order, (0x50,7) twice
        arm(5);
        wr(32'h50, 32'h7);
        wr(32'h50, 32'h7);
        for (int i = 2; i < 5; i++) wr(ea[i], ed[i]);
        check("dup_err", a_err, 1);
        check("dup_idx", a_eidx, 1);
        check("dup_addr", a_eaddr, 32'h50);
        check("dup_match", a_match, 4);
        check("dup_pass", a_pass, 0);

        // inactivity timeout 16 cycles after second write
        arm(5);
        wr(ea[0], ed[0]);
        wr(ea[1], ed[1]);
        step(15);
        check("to_early_done", o_done, 0);
        check("to_early_busy", o_busy, 1);
        step();
        check("to_timeout", o_timeout, 1);
        check("to_done", o_done, 1);
        check("to_match", o_match, 2);
        check("to_pass", o_pass, 0);

        // write on the 16th cycle keeps the run alive
        arm(5);
        wr(ea[0], ed[0]);
        wr(ea[1], ed[1]);
        step(15);
        wr(ea[2], ed[2]);
        check("edge_timeout", o_timeout, 0);
        check("edge_busy", o_busy, 1);
        check("edge_match", o_match, 3);
        wr(ea[3], ed[3]);
        wr(ea[4], ed[4]);
        check("edge_pass", o_pass, 1);

        // zero expected entries
        arm(0);
        check("zero_done", o_done, 1);
        check("zero_pass", o_pass, 1);
        check("zero_busy", o_busy, 0);

        // load during RUN is dropped
        arm(5);
        wr(ea[0], ed[0]);
        load(3'd0, 32'h99, 32'h99);
        for (int i = 1; i < 5; i++) wr(ea[i], ed[i]);
        arm(5);
        for (int i = 0; i < 5; i++) wr(ea[i], ed[i]);
        check("runload_pass", o_pass, 1);
        check("runload_match", o_match, 5);

        // asynchronous reset mid-run
        arm(5);
        for (int i = 0; i < 3; i++) wr(ea[i], ed[i]);
        check("pre_rst_match", o_match, 3);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", o_busy, 0);
        check("arst_match", o_match, 0);
        check("arst_done", o_done, 0);
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 3; i++) load(3'(i), 32'h100 + 32'(4 * i), 32'(i + 1));
        arm(3);
        for (int i = 0; i < 3; i++) wr(32'h100 + 32'(4 * i), 32'(i + 1));
        check("post_rst_pass", o_pass, 1);
        check("post_rst_match", o_match, 3);
        check("post_rst_any_pass", a_pass, 1);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
